// File: rtl/stage_if_prefetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stage_if_prefetch_if: fetch-to-memory read/ready bus               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface stage_if_prefetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              ram_read;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_ready;
  logic [INST_W-1:0] ram_data;

  modport master (output ram_read, output ram_addr, input ram_ready, input ram_data);
  modport slave  (input ram_read, input ram_addr, output ram_ready, output ram_data);
endinterface
`default_nettype wire

// File: rtl/stage_if_prefetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stage_if_prefetch: instruction fetch stage with prefetch FIFO      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module stage_if_prefetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  wire logic                         clk,
  input  wire logic                         reset,
  input  wire logic                         br_valid,
  input  wire logic [ADDR_W-1:0]            br_target,
  input  wire logic                         stall_down,
  stage_if_prefetch_if.master               mem,
  output logic                              valid_o,
  output logic [ADDR_W-1:0]                 pc_o,
  output logic [INST_W-1:0]                 inst_o,
  output logic                              stall_if,
  output logic [$clog2(DEPTH+1)-1:0]        count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_ram_read;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [INST_W-1:0] r_inst_mem [DEPTH];

  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic [CNT_W-1:0]  w_next_count;
  logic [ADDR_W-1:0] w_br_pc;
  logic [ADDR_W-1:0] w_pc_inc;

  assign w_valid      = (r_count != '0);
  assign w_pop        = w_valid && !stall_down && !br_valid;
  assign w_push       = (r_state == S_REQ) && mem.ram_ready && !br_valid;
  assign w_next_count = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_br_pc      = br_target & ~ADDR_W'(3);
  assign w_pc_inc     = r_pc + ADDR_W'(PC_STEP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_ram_read <= 1'b0;
      r_ram_addr <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (br_valid) begin
      // Flush; an outstanding request is never aborted, only marked stale.
      r_pc     <= w_br_pc;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      if (r_state == S_IDLE || mem.ram_ready) begin
        r_ram_read <= 1'b1;
        r_ram_addr <= w_br_pc;
        r_state    <= S_REQ;
      end else begin
        r_state <= S_DISCARD;
      end
    end else begin
      r_count <= w_next_count;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      case (r_state)
        S_IDLE: begin
          if (r_count < CNT_W'(DEPTH)) begin
            r_ram_read <= 1'b1;
            r_ram_addr <= r_pc;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem.ram_ready) begin
            r_pc <= w_pc_inc;
            if (w_next_count < CNT_W'(DEPTH)) begin
              r_ram_addr <= w_pc_inc;
            end else begin
              r_ram_read <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
        end
        S_DISCARD: begin
          if (mem.ram_ready) begin
            r_ram_addr <= r_pc;
            r_state    <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage needs no reset: the head is qualified by the occupancy count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]   <= r_ram_addr;
      r_inst_mem[r_wr_ptr] <= mem.ram_data;
    end
  end

  assign mem.ram_read = r_ram_read;
  assign mem.ram_addr = r_ram_addr;
  assign valid_o      = w_valid;
  assign stall_if     = !w_valid;
  assign count        = r_count;
  assign pc_o         = w_valid ? r_pc_mem[r_rd_ptr]   : '0;
  assign inst_o       = w_valid ? r_inst_mem[r_rd_ptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_stage_if_prefetch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_stage_if_prefetch: random + directed bench with queue model     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_stage_if_prefetch;

  localparam int          ADDR_W   = 32;
  localparam int          INST_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0040;
  localparam int          PC_STEP  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_valid;
  logic [31:0] br_target;
  logic        stall_down;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        stall_if;
  logic [2:0]  count;

  stage_if_prefetch_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) mem_bus ();

  stage_if_prefetch #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH),
    .RESET_PC(RESET_PC), .PC_STEP(PC_STEP)
  ) dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_target(br_target),
    .stall_down(stall_down), .mem(mem_bus), .valid_o(valid_o), .pc_o(pc_o),
    .inst_o(inst_o), .stall_if(stall_if), .count(count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of fetched words, next-fetch pc, and what the
  // single outstanding request is (0 none, 1 live, 2 stale after redirect).
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc, m_addr;
  logic        m_read;
  int          m_out;

  // Memory responder and stimulus knobs.
  bit busy;
  int wt;
  int lat_lo, lat_hi;
  bit spurious;
  int br_prob;     // 0 never, else 1-in-N
  int stall_mode;  // 0 never, 1 always, else 1-in-N

  task automatic model_reset();
    q.delete();
    m_pc = RESET_PC; m_addr = '0; m_read = 1'b0; m_out = 0;
  endtask

  task automatic model_step();
    bit   rdy = mem_bus.ram_ready;
    bit   pop = (q.size() != 0) && !stall_down && !br_valid;
    ent_t e;
    if (br_valid) begin
      q.delete();
      m_pc = br_target & ~32'h3;
      if (m_out == 0 || rdy) begin
        m_out = 1; m_read = 1'b1; m_addr = m_pc;
      end else begin
        m_out = 2;
      end
    end else if (m_out == 1 && rdy) begin
      e.pc = m_addr; e.inst = mem_bus.ram_data;
      q.push_back(e);
      m_pc = m_pc + PC_STEP;
      if (pop) void'(q.pop_front());
      if (q.size() < DEPTH) m_addr = m_pc;
      else begin m_read = 1'b0; m_out = 0; end
    end else begin
      if (m_out == 2 && rdy) begin
        m_out = 1; m_addr = m_pc;
      end else if (m_out == 0 && q.size() < DEPTH) begin
        m_out = 1; m_read = 1'b1; m_addr = m_pc;
      end
      if (pop) void'(q.pop_front());
    end
  endtask

  task automatic check_outputs();
    bit ne = (q.size() != 0);
    check("ram_read", mem_bus.ram_read, m_read);
    check("ram_addr", mem_bus.ram_addr, m_addr);
    check("valid_o",  valid_o, ne);
    check("stall_if", stall_if, !ne);
    check("count",    count, q.size());
    check("pc_o",     pc_o, ne ? q[0].pc : 32'h0);
    check("inst_o",   inst_o, ne ? q[0].inst : 32'h0);
  endtask

  task automatic mem_step();
    if (mem_bus.ram_ready) busy = 1'b0;
    mem_bus.ram_ready = 1'b0;
    if (!busy && mem_bus.ram_read) begin
      busy = 1'b1;
      wt   = $urandom_range(lat_hi, lat_lo);
    end
    if (busy) begin
      if (wt == 0) begin
        mem_bus.ram_ready = 1'b1;
        mem_bus.ram_data  = $urandom;
      end else begin
        wt--;
      end
    end else if (spurious && $urandom_range(0, 5) == 0) begin
      mem_bus.ram_ready = 1'b1;
      mem_bus.ram_data  = $urandom;
    end
  endtask

  task automatic drive_rand();
    br_valid   = (br_prob != 0) && ($urandom_range(0, br_prob - 1) == 0);
    br_target  = $urandom;
    stall_down = (stall_mode == 1) ||
                 ((stall_mode > 1) && ($urandom_range(0, stall_mode - 1) == 0));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    mem_step();
    drive_rand();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset(input bit stale);
    reset = 1'b1;
    #1;
    check("rst_ram_read", mem_bus.ram_read, 1'b0);
    check("rst_ram_addr", mem_bus.ram_addr, 32'h0);
    check("rst_valid_o",  valid_o, 1'b0);
    check("rst_pc_o",     pc_o, 32'h0);
    check("rst_inst_o",   inst_o, 32'h0);
    check("rst_count",    count, 3'd0);
    check("rst_stall_if", stall_if, 1'b1);
    model_reset();
    busy = 1'b0;
    mem_bus.ram_ready = 1'b0;
    br_valid = 1'b0; br_target = '0; stall_down = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    // A late ready from the abandoned request lands on the first edge.
    mem_bus.ram_ready = stale;
    mem_bus.ram_data  = 32'hDEAD_BEEF;
  endtask

  task automatic knobs(input int lo, input int hi, input int brp, input int stm, input bit sp);
    lat_lo = lo; lat_hi = hi; br_prob = brp; stall_mode = stm; spurious = sp;
  endtask

  initial begin
    int k;
    mem_bus.ram_ready = 1'b0;
    mem_bus.ram_data  = '0;
    knobs(2, 2, 0, 0, 0);
    do_reset(1'b0);

    // Steady sequential fetch with fixed latency.
    run(25);

    // Fill under stall, then drain.
    knobs(0, 0, 0, 1, 0);
    drive_rand();
    run(12);
    check("full_count", count, 3'd4);
    check("full_read",  mem_bus.ram_read, 1'b0);
    stall_down = 1'b0;
    knobs(0, 0, 0, 0, 0);
    run(12);

    // Redirect while a request is pending.
    knobs(3, 3, 0, 0, 0);
    do_reset(1'b0);
    k = 0;
    while (!(mem_bus.ram_read && !mem_bus.ram_ready && mem_bus.ram_addr == RESET_PC + 8) && k < 60) begin
      cycle(); k++;
    end
    check("wait_req8", k < 60, 1'b1);
    br_valid = 1'b1; br_target = 32'h100;
    cycle();
    check("br_flush_valid", valid_o, 1'b0);
    run(15);

    // Redirect on the same edge as ready, unaligned target.
    knobs(1, 1, 0, 0, 0);
    k = 0;
    while (!mem_bus.ram_ready && k < 20) begin cycle(); k++; end
    check("wait_ready", k < 20, 1'b1);
    br_valid = 1'b1; br_target = 32'h103;
    cycle();
    check("br_rdy_addr", mem_bus.ram_addr, 32'h100);
    run(10);

    // Two redirects while the stale request is outstanding.
    knobs(5, 5, 0, 0, 0);
    k = 0;
    while (!(busy && wt >= 3) && k < 30) begin cycle(); k++; end
    check("wait_busy", k < 30, 1'b1);
    br_valid = 1'b1; br_target = 32'h200;
    cycle();
    br_valid = 1'b1; br_target = 32'h300;
    cycle();
    run(20);

    // Asynchronous reset mid-request with two entries queued.
    knobs(1, 1, 0, 1, 0);
    drive_rand();
    k = 0;
    while (!(count == 3'd2 && mem_bus.ram_read && !mem_bus.ram_ready) && k < 30) begin
      cycle(); k++;
    end
    check("wait_two", k < 30, 1'b1);
    #2;
    knobs(0, 3, 0, 0, 0);
    do_reset(1'b1);
    run(10);

    // Random mix.
    knobs(0, 3, 16, 3, 1);
    run(2000);
    knobs(0, 2, 24, 2, 1);
    run(1500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
